// File: rtl/xm_mem_unit.sv
// Handshaked load/store unit for the X-Makina core: byte-lane steering, alignment check, req/ack bus.
// Optional bus timeout enabled by defining XM_MEM_TIMEOUT_EN.
module xm_mem_unit #(
  parameter int WORD    = 16,
  parameter int LANES   = WORD/8,
  parameter int LSB     = $clog2(WORD/8),
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                start_i,
  input  logic                wr_i,
  input  logic                byte_i,
  input  logic [WORD-1:0]     addr_i,
  input  logic [WORD-1:0]     wdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [WORD-1:0]     rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [LANES-1:0]    mem_be_o,
  output logic [WORD-LSB-1:0] mem_addr_o,
  output logic [WORD-1:0]     mem_wdata_o,
  input  logic [WORD-1:0]     mem_rdata_i,
  input  logic                mem_ack_i
);

  if ((WORD % 8) != 0 || WORD < 16 || TIMEOUT < 1) begin : g_bad_param
    $error("xm_mem_unit: illegal WORD or TIMEOUT");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ERR} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [WORD-1:0]     r_rdata;
  logic                r_req;
  logic                r_we;
  logic [LANES-1:0]    r_be;
  logic [WORD-LSB-1:0] r_addr;
  logic [WORD-1:0]     r_wdata;
  logic [LSB-1:0]      r_lane;
  logic                r_byte;

  logic                w_misalign;
  logic [LANES-1:0]    w_be;
  logic [WORD-1:0]     w_wdata;
  logic [WORD-1:0]     w_rd_shift;
  logic [WORD-1:0]     w_rd_load;

`ifdef XM_MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] r_cnt;
`endif

  always_comb begin
    w_misalign = !byte_i && (addr_i[LSB-1:0] != '0);
    w_be       = byte_i ? (LANES'(1) << addr_i[LSB-1:0]) : {LANES{1'b1}};
    w_wdata    = byte_i ? {LANES{wdata_i[7:0]}} : wdata_i;
    // Bring the addressed lane down to bits 7:0 for byte loads.
    w_rd_shift = mem_rdata_i >> {r_lane, 3'b000};
    w_rd_load  = r_byte ? {{(WORD-8){1'b0}}, w_rd_shift[7:0]} : mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lane  <= '0;
      r_byte  <= 1'b0;
`ifdef XM_MEM_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_busy <= 1'b1;
            if (w_misalign) begin
              r_state <= S_ERR;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_we    <= wr_i;
              r_be    <= w_be;
              r_addr  <= addr_i[WORD-1:LSB];
              r_wdata <= w_wdata;
              r_lane  <= addr_i[LSB-1:0];
              r_byte  <= byte_i;
`ifdef XM_MEM_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (!r_we) r_rdata <= w_rd_load;
          end
`ifdef XM_MEM_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule

// File: doc/xm_mem_unit.md
Name: xm_mem_unit

Overview:
- Parametrised memory access unit for the X-Makina multi-cycle core. It replaces the datapath's bare MAR/MDR capture with a handshaked load/store engine.
- The controller issues one access: address, word or byte size, read or write. The unit drives a req/ack memory bus, performs byte-lane steering and alignment checking, and returns zero-extended read data with a one-cycle done pulse.
- Sits between the datapath register file/ALU and external memory.

Parameters:
- WORD, 16, data word width in bits; must be a multiple of 8 and at least 16.
- LANES, WORD/8, number of byte lanes (derived; do not override).
- LSB, $clog2(WORD/8), number of byte-offset address bits (derived).
- TIMEOUT, 255, maximum cycles to wait for mem_ack_i; used only with XM_MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- arst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  access request from controller; sampled only when busy_o=0.
- wr_i  in  1  1=store, 0=load; sampled with start_i.
- byte_i  in  1  1=byte access, 0=word access; sampled with start_i.
- addr_i  in  WORD  byte address; sampled with start_i.
- wdata_i  in  WORD  store data; for byte stores only bits 7:0 are used.
- busy_o  out  1  access in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle error pulse, coincident with done_o.
- rdata_o  out  WORD  load result, zero-extended for byte loads.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_be_o  out  LANES  byte-lane enables.
- mem_addr_o  out  WORD-LSB  word address (addr_i[WORD-1:LSB]).
- mem_wdata_o  out  WORD  bus write data.
- mem_rdata_i  in  WORD  bus read data; valid when mem_ack_i=1.
- mem_ack_i  in  1  bus acknowledge.

Behaviour:
- Clock and reset: single clock domain, clk_i. Reset is asynchronous, active-low on arst_ni.
- Reset values: state=IDLE; busy_o, done_o, err_o, mem_req_o, mem_we_o = 0; mem_be_o, mem_addr_o, mem_wdata_o, rdata_o = 0.
- State machine: IDLE, REQ, ERR.
- IDLE, start_i=1, access misaligned (byte_i=0 and addr_i[LSB-1:0]!=0):
  - Go to ERR. No bus request is issued.
  - busy_o=1 for one cycle, then done_o=err_o=1 for one cycle on return to IDLE.
  - rdata_o is unchanged.
- IDLE, start_i=1, access aligned:
  - At the next edge, register mem_addr_o=addr_i[WORD-1:LSB] and mem_we_o=wr_i.
  - Set mem_req_o=1 and busy_o=1; state=REQ.
- Byte lane L=addr_i[LSB-1:0], little-endian (lane 0 = bits 7:0).
  - Byte access: mem_be_o=one-hot(L); byte stores replicate wdata_i[7:0] across all lanes of mem_wdata_o.
  - Word access: mem_be_o=all ones; mem_wdata_o=wdata_i.
- REQ: mem_req_o and all bus outputs are held stable until mem_ack_i=1 is sampled.
- On the ack edge:
  - mem_req_o=0, busy_o=0, done_o=1 for one cycle, state=IDLE.
  - Loads capture rdata_o: a word load takes mem_rdata_i; a byte load takes mem_rdata_i lane L in bits 7:0, zero-extended.
  - Stores leave rdata_o unchanged.
- mem_ack_i outside REQ is ignored.
- Latency: start edge to first mem_req_o cycle = 1. With ack in the first REQ cycle, done_o is high in cycle start+2.
- start_i while busy_o=1 is ignored and not queued. start_i in the done_o cycle is accepted, giving back-to-back accesses.
- Reset asserted mid-access: immediate return to reset values; the pending access is abandoned and done_o is not asserted.

Optional Feature:
- Macro: XM_MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - After TIMEOUT cycles without ack: mem_req_o=0, done_o=err_o=1 for one cycle, state=IDLE, rdata_o unchanged.
  - Ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter exists; REQ waits indefinitely for mem_ack_i.

Test Plan:
- Reset released, then word load addr_i=16'h0100, ack in first REQ cycle, mem_rdata_i=16'hBEEF:
  - mem_addr_o=15'h0080, mem_be_o=2'b11, mem_we_o=0.
  - done_o in cycle start+2; rdata_o=16'hBEEF; err_o=0.
- Byte load addr_i=16'h0101, mem_rdata_i=16'hA55A, ack after 3 wait cycles:
  - mem_be_o=2'b10, mem_req_o high 4 cycles, rdata_o=16'h00A5.
- Byte store addr_i=16'h0200, wdata_i=16'h1234:
  - mem_we_o=1, mem_be_o=2'b01, mem_wdata_o=16'h3434; rdata_o unchanged after done_o.
- Misaligned word store addr_i=16'h0003:
  - mem_req_o stays 0; done_o=err_o=1 two cycles after start.
- start_i pulsed during REQ with a different address: ignored, bus outputs unchanged. Then start_i in the done_o cycle: a second access begins the next cycle.
- XM_MEM_TIMEOUT_EN defined, TIMEOUT=4, mem_ack_i held 0:
  - mem_req_o high 4 cycles, then done_o=err_o=1.
  - arst_ni low mid-REQ: all outputs zero at once, no done_o.
